gemm_param_if_v2: RTL and testbench

- Parametrised NICE custom-instruction front end for the GEMM accelerator.
- Holds a configurable bank of parameter pairs written by single-cycle instructions.
- Validates completeness before launching the compute engine.
- Tracks the run with a FSM and returns a multi-cycle response carrying a cycle count and an error flag.
- Adds pair readback, status read, clear, and run-length measurement.

---
 rtl/gemm_param_if_v2_if.sv | 35 +++
 rtl/gemm_param_if_v2.sv | 189 ++++++++++++++++++
 tb/tb_gemm_param_if_v2.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_param_if_v2_if.sv
// NICE request / single-cycle / multi-cycle response bundle between the core and
// the GEMM parameter front end.
interface gemm_param_if_v2_if #(
    parameter int unsigned DW = 32
) ();
    logic          nice_req_valid;
    logic          nice_req_ready;
    logic [31:0]   nice_req_instr;
    logic [DW-1:0] nice_req_rs1;
    logic [DW-1:0] nice_req_rs2;
    logic          nice_rsp_1cyc_type;
    logic [DW-1:0] nice_rsp_1cyc_dat;
    logic [DW-1:0] nice_rsp_1cyc_dat_1;
    logic          nice_rsp_1cyc_err;
    logic          nice_rsp_multicyc_valid;
    logic          nice_rsp_multicyc_ready;
    logic [DW-1:0] nice_rsp_multicyc_dat;
    logic          nice_rsp_multicyc_err;

    modport master (
        output nice_req_valid, nice_req_instr, nice_req_rs1, nice_req_rs2,
               nice_rsp_multicyc_ready,
        input  nice_req_ready, nice_rsp_1cyc_type, nice_rsp_1cyc_dat, nice_rsp_1cyc_dat_1,
               nice_rsp_1cyc_err, nice_rsp_multicyc_valid, nice_rsp_multicyc_dat,
               nice_rsp_multicyc_err
    );

    modport slave (
        input  nice_req_valid, nice_req_instr, nice_req_rs1, nice_req_rs2,
               nice_rsp_multicyc_ready,
        output nice_req_ready, nice_rsp_1cyc_type, nice_rsp_1cyc_dat, nice_rsp_1cyc_dat_1,
               nice_rsp_1cyc_err, nice_rsp_multicyc_valid, nice_rsp_multicyc_dat,
               nice_rsp_multicyc_err
    );
endinterface

// File: rtl/gemm_param_if_v2.sv
// NICE front end for the GEMM engine: parameter-pair bank, completeness-checked
// launch, run FSM with saturating cycle counter and a multi-cycle response.
module gemm_param_if_v2 #(
    parameter int unsigned          DW        = 32,
    parameter int unsigned          NUM_PAIRS = 8,
    parameter logic [6:0]           OPCODE    = 7'b0101011,
    parameter logic [NUM_PAIRS-1:0] REQ_MASK  = {NUM_PAIRS{1'b1}},
    parameter bit                   AUTO_CLR  = 1'b1
) (
    input  logic                      nice_clk,
    input  logic                      nice_rst_n,
    gemm_param_if_v2_if.slave         nice,
    input  logic                      fin,
    output logic                      start,
    output logic [2*NUM_PAIRS*DW-1:0] param_flat,
    output logic [NUM_PAIRS-1:0]      param_vld,
    output logic                      busy
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StRsp  = 2'd2;

    localparam logic [2:0] F3Wr    = 3'b000;
    localparam logic [2:0] F3Rd    = 3'b001;
    localparam logic [2:0] F3Start = 3'b010;
    localparam logic [2:0] F3Clr   = 3'b011;
    localparam logic [2:0] F3Stat  = 3'b100;

    logic [1:0]           state_q, state_d;
    logic [DW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0]        mdat_q, mdat_d;
    logic                 merr_q, merr_d;
    logic [NUM_PAIRS-1:0] vld_q, vld_d;
    logic [DW-1:0]        rs1_q [NUM_PAIRS];
    logic [DW-1:0]        rs2_q [NUM_PAIRS];

    logic                 acc, in_range, complete, wr_en;
    logic [2:0]           f3;
    logic [6:0]           idx;
    int unsigned          idx_ext;
    logic [DW-1:0]        rd0, rd1, stat_vld, stat_mask;
    logic                 unused_instr;

    // Zero-extend (or truncate) the pair bitmaps into a data word.
    logic [DW+NUM_PAIRS-1:0] vld_ext, mask_ext;
    assign vld_ext   = {{DW{1'b0}}, vld_q};
    assign mask_ext  = {{DW{1'b0}}, REQ_MASK};
    assign stat_vld  = vld_ext[DW-1:0];
    assign stat_mask = mask_ext[DW-1:0];

    assign f3           = nice.nice_req_instr[14:12];
    assign idx          = nice.nice_req_instr[31:25];
    assign idx_ext      = 32'(idx);
    assign in_range     = idx_ext < NUM_PAIRS;
    assign unused_instr = ^{nice.nice_req_instr[24:15], nice.nice_req_instr[11:7]};

    assign nice.nice_req_ready = (state_q == StIdle);
    assign acc      = nice.nice_req_valid & nice.nice_req_ready &
                      (nice.nice_req_instr[6:0] == OPCODE);
    assign complete = (vld_q & REQ_MASK) == REQ_MASK;
    assign cnt_inc  = (cnt_q == {DW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    assign nice.nice_rsp_multicyc_valid = (state_q == StRsp);
    assign nice.nice_rsp_multicyc_dat   = mdat_q;
    assign nice.nice_rsp_multicyc_err   = merr_q;
    assign busy      = (state_q != StIdle);
    assign param_vld = vld_q;

    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_flat
        assign param_flat[(2*p)*DW +: DW]   = rs1_q[p];
        assign param_flat[(2*p+1)*DW +: DW] = rs2_q[p];
    end

    always_comb begin
        rd0 = '0;
        rd1 = '0;
        for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
            if (idx_ext == p) begin
                rd0 = rs1_q[p];
                rd1 = rs2_q[p];
            end
        end
    end

    // Single-cycle response: purely combinational, zero unless a request is accepted.
    always_comb begin
        nice.nice_rsp_1cyc_type  = 1'b0;
        nice.nice_rsp_1cyc_dat   = '0;
        nice.nice_rsp_1cyc_dat_1 = '0;
        nice.nice_rsp_1cyc_err   = 1'b0;
        start                    = 1'b0;
        if (acc) begin
            case (f3)
                F3Wr: begin
                    nice.nice_rsp_1cyc_type = 1'b1;
                    nice.nice_rsp_1cyc_err  = ~in_range;
                end
                F3Rd: begin
                    nice.nice_rsp_1cyc_type  = 1'b1;
                    nice.nice_rsp_1cyc_dat   = rd0;
                    nice.nice_rsp_1cyc_dat_1 = rd1;
                    nice.nice_rsp_1cyc_err   = ~in_range;
                end
                F3Start: start = complete;
                F3Clr:   nice.nice_rsp_1cyc_type = 1'b1;
                F3Stat: begin
                    nice.nice_rsp_1cyc_type  = 1'b1;
                    nice.nice_rsp_1cyc_dat   = stat_vld;
                    nice.nice_rsp_1cyc_dat_1 = stat_mask;
                end
                default: begin
                    nice.nice_rsp_1cyc_type = 1'b1;
                    nice.nice_rsp_1cyc_err  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdat_d  = mdat_q;
        merr_d  = merr_q;
        vld_d   = vld_q;
        wr_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (acc && f3 == F3Wr && in_range) begin
                    wr_en = 1'b1;
                    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
                        if (idx_ext == p) vld_d[p] = 1'b1;
                    end
                end else if (acc && f3 == F3Clr) begin
                    vld_d = '0;
                end else if (acc && f3 == F3Start) begin
                    if (complete) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        merr_d  = 1'b0;
                    end else begin
                        state_d = StRsp;
                        merr_d  = 1'b1;
                        mdat_d  = '0;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_inc;
                if (fin) begin
                    mdat_d  = cnt_inc;
                    state_d = StRsp;
                end
            end
            StRsp: begin
                if (nice.nice_rsp_multicyc_ready) begin
                    state_d = StIdle;
                    if (AUTO_CLR && !merr_q) vld_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mdat_q  <= '0;
            merr_q  <= 1'b0;
            vld_q   <= '0;
            for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
                rs1_q[p] <= '0;
                rs2_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdat_q  <= mdat_d;
            merr_q  <= merr_d;
            vld_q   <= vld_d;
            for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
                if (wr_en && idx_ext == p) begin
                    rs1_q[p] <= nice.nice_req_rs1;
                    rs2_q[p] <= nice.nice_req_rs2;
                end
            end
        end
    end
endmodule

// File: tb/tb_gemm_param_if_v2.sv
// Bench for gemm_param_if_v2: table of single-cycle vectors plus hand-written run
// sequences whose multi-cycle responses go through a scoreboard queue.
module tb_gemm_param_if_v2;
    localparam int unsigned DW = 32;
    localparam int unsigned NP = 8;
    localparam logic [6:0]  OPC = 7'b0101011;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  idx;
        logic [31:0] rs1, rs2;
        logic        e_type, e_err;
        logic [31:0] e_dat, e_dat1;
        logic [7:0]  e_vld;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    logic            nice_clk = 1'b0;
    logic            nice_rst_n = 1'b0;
    logic            fin = 1'b0;
    logic            start;
    logic [2*NP*DW-1:0] param_flat;
    logic [NP-1:0]   param_vld;
    logic            busy;
    int              n_cmp = 0;
    int              n_bad = 0;
    vec_t            tbl[$];
    rsp_t            sb[$];

    gemm_param_if_v2_if #(.DW(DW)) nif ();

    gemm_param_if_v2 dut (
        .nice_clk   (nice_clk),
        .nice_rst_n (nice_rst_n),
        .nice       (nif),
        .fin        (fin),
        .start      (start),
        .param_flat (param_flat),
        .param_vld  (param_vld),
        .busy       (busy)
    );

    always #5 nice_clk = ~nice_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Checks any visible multi-cycle response against the scoreboard head.
    task automatic mon();
        rsp_t e;
        if (nif.nice_rsp_multicyc_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", 64'(nif.nice_rsp_multicyc_valid), 64'd0);
            end else begin
                e = sb[0];
                chk("rsp_dat", 64'(nif.nice_rsp_multicyc_dat), 64'(e.dat));
                chk("rsp_err", 64'(nif.nice_rsp_multicyc_err), 64'(e.err));
                if (nif.nice_rsp_multicyc_ready) void'(sb.pop_front());
            end
        end
    endtask

    task automatic half();
        @(negedge nice_clk);
        mon();
    endtask

    task automatic edge_();
        @(posedge nice_clk);
        #1;
    endtask

    function automatic logic [31:0] ins(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] idx);
        return {idx, 10'b0, f3, 5'b0, opc};
    endfunction

    task automatic req_set(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] idx,
                           input logic [31:0] rs1, input logic [31:0] rs2);
        nif.nice_req_valid = 1'b1;
        nif.nice_req_instr = ins(opc, f3, idx);
        nif.nice_req_rs1   = rs1;
        nif.nice_req_rs2   = rs2;
    endtask

    task automatic req_clr();
        nif.nice_req_valid = 1'b0;
        nif.nice_req_instr = '0;
    endtask

    task automatic wr(input int i, input logic [31:0] rs1, input logic [31:0] rs2);
        req_set(OPC, 3'b000, 7'(i), rs1, rs2);
        half();
        edge_();
        req_clr();
    endtask

    function automatic vec_t mkv(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [6:0] idx, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic e_type, input logic e_err,
                                 input logic [31:0] e_dat, input logic [31:0] e_dat1,
                                 input logic [7:0] e_vld);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.idx = idx; v.rs1 = rs1; v.rs2 = rs2;
        v.e_type = e_type; v.e_err = e_err; v.e_dat = e_dat; v.e_dat1 = e_dat1;
        v.e_vld = e_vld;
        return v;
    endfunction

    initial begin
        rsp_t r;
        nif.nice_req_valid = 1'b0;
        nif.nice_req_instr = '0;
        nif.nice_req_rs1 = '0;
        nif.nice_req_rs2 = '0;
        nif.nice_rsp_multicyc_ready = 1'b0;

        // Vector table: write all pairs, then readback / error / status / clear cases.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mkv(OPC, 3'b000, 7'(i), 32'h100 + 32'(i), 32'h200 + 32'(i),
                              1'b1, 1'b0, 32'h0, 32'h0, 8'((16'h1 << (i + 1)) - 1)));
        end
        tbl.push_back(mkv(OPC, 3'b001, 7'd3, 0, 0, 1, 0, 32'h103, 32'h203, 8'hFF));
        tbl.push_back(mkv(OPC, 3'b001, 7'd9, 0, 0, 1, 1, 32'h0, 32'h0, 8'hFF));
        tbl.push_back(mkv(OPC, 3'b000, 7'd9, 32'hDEAD, 32'hBEEF, 1, 1, 0, 0, 8'hFF));
        tbl.push_back(mkv(OPC, 3'b001, 7'd1, 0, 0, 1, 0, 32'h101, 32'h201, 8'hFF));
        tbl.push_back(mkv(OPC, 3'b111, 7'd0, 0, 0, 1, 1, 0, 0, 8'hFF));
        tbl.push_back(mkv(OPC, 3'b101, 7'd0, 0, 0, 1, 1, 0, 0, 8'hFF));
        tbl.push_back(mkv(OPC, 3'b100, 7'd0, 0, 0, 1, 0, 32'hFF, 32'hFF, 8'hFF));
        tbl.push_back(mkv(OPC, 3'b011, 7'd0, 0, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(OPC, 3'b100, 7'd0, 0, 0, 1, 0, 32'h0, 32'hFF, 8'h00));
        tbl.push_back(mkv(OPC, 3'b001, 7'd3, 0, 0, 1, 0, 32'h103, 32'h203, 8'h00));
        tbl.push_back(mkv(7'b0001011, 3'b001, 7'd3, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(7'b0001011, 3'b000, 7'd2, 32'h77, 32'h88, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(OPC, 3'b000, 7'd2, 32'h55, 32'h66, 1, 0, 0, 0, 8'h04));
        tbl.push_back(mkv(OPC, 3'b001, 7'd2, 0, 0, 1, 0, 32'h55, 32'h66, 8'h04));

        // Reset state
        #1;
        chk("rst_vld", 64'(param_vld), 64'd0);
        chk("rst_flat", 64'(|param_flat), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_mvalid", 64'(nif.nice_rsp_multicyc_valid), 64'd0);
        chk("rst_mdat", 64'(nif.nice_rsp_multicyc_dat), 64'd0);
        chk("rst_merr", 64'(nif.nice_rsp_multicyc_err), 64'd0);
        chk("rst_ready", 64'(nif.nice_req_ready), 64'd1);
        @(negedge nice_clk);
        nice_rst_n = 1'b1;
        edge_();

        foreach (tbl[i]) begin
            req_set(tbl[i].opc, tbl[i].f3, tbl[i].idx, tbl[i].rs1, tbl[i].rs2);
            half();
            chk($sformatf("v%0d_type", i), 64'(nif.nice_rsp_1cyc_type), 64'(tbl[i].e_type));
            chk($sformatf("v%0d_err", i), 64'(nif.nice_rsp_1cyc_err), 64'(tbl[i].e_err));
            chk($sformatf("v%0d_dat", i), 64'(nif.nice_rsp_1cyc_dat), 64'(tbl[i].e_dat));
            chk($sformatf("v%0d_dat1", i), 64'(nif.nice_rsp_1cyc_dat_1), 64'(tbl[i].e_dat1));
            chk($sformatf("v%0d_ready", i), 64'(nif.nice_req_ready), 64'd1);
            edge_();
            req_clr();
            chk($sformatf("v%0d_vld", i), 64'(param_vld), 64'(tbl[i].e_vld));
        end
        chk("flat_slot6", 64'(param_flat[6*DW +: DW]), 64'h103);
        chk("flat_slot7", 64'(param_flat[7*DW +: DW]), 64'h203);
        chk("flat_slot4", 64'(param_flat[4*DW +: DW]), 64'h55);

        // Incomplete START: error response, no launch
        for (int i = 0; i < 7; i++) wr(i, 32'h300 + 32'(i), 32'h380 + 32'(i));
        chk("t2_vld", 64'(param_vld), 64'h7F);
        req_set(OPC, 3'b010, 7'd0, 0, 0);
        half();
        chk("t2_start", 64'(start), 64'd0);
        chk("t2_type", 64'(nif.nice_rsp_1cyc_type), 64'd0);
        r.dat = 32'd0; r.err = 1'b1; sb.push_back(r);
        edge_();
        req_clr();
        half();
        chk("t2_busy", 64'(busy), 64'd1);
        edge_();
        nif.nice_rsp_multicyc_ready = 1'b1;
        half();
        edge_();
        nif.nice_rsp_multicyc_ready = 1'b0;
        half();
        chk("t2_mvalid_drop", 64'(nif.nice_rsp_multicyc_valid), 64'd0);
        chk("t2_ready", 64'(nif.nice_req_ready), 64'd1);
        chk("t2_vld_kept", 64'(param_vld), 64'h7F);
        edge_();

        // Good run: fin on the 10th RUN cycle, response held under backpressure
        wr(7, 32'h307, 32'h387);
        req_set(OPC, 3'b010, 7'd0, 0, 0);
        half();
        chk("t3_start", 64'(start), 64'd1);
        chk("t3_busy_acc", 64'(busy), 64'd0);
        r.dat = 32'd10; r.err = 1'b0; sb.push_back(r);
        edge_();
        req_clr();
        for (int c = 1; c <= 10; c++) begin
            fin = (c == 10);
            half();
            chk($sformatf("t3_start_c%0d", c), 64'(start), 64'd0);
            chk($sformatf("t3_busy_c%0d", c), 64'(busy), 64'd1);
            chk($sformatf("t3_mvalid_c%0d", c), 64'(nif.nice_rsp_multicyc_valid), 64'd0);
            edge_();
        end
        fin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            half();
            chk($sformatf("t3_rsp_valid_%0d", c), 64'(nif.nice_rsp_multicyc_valid), 64'd1);
            chk($sformatf("t3_rsp_busy_%0d", c), 64'(busy), 64'd1);
            edge_();
        end
        nif.nice_rsp_multicyc_ready = 1'b1;
        half();
        edge_();
        nif.nice_rsp_multicyc_ready = 1'b0;
        half();
        chk("t3_autoclr", 64'(param_vld), 64'd0);
        chk("t3_busy_end", 64'(busy), 64'd0);
        chk("t3_mvalid_end", 64'(nif.nice_rsp_multicyc_valid), 64'd0);
        edge_();

        // Requests during RUN are refused; fin while idle is ignored
        for (int i = 0; i < 8; i++) wr(i, 32'h400 + 32'(i), 32'h480 + 32'(i));
        req_set(OPC, 3'b010, 7'd0, 0, 0);
        half();
        chk("t5_start", 64'(start), 64'd1);
        r.dat = 32'd4; r.err = 1'b0; sb.push_back(r);
        edge_();
        for (int c = 1; c <= 4; c++) begin
            if (c <= 2) req_set(OPC, 3'b000, 7'd0, 32'hBAD, 32'hBAD);
            else req_clr();
            fin = (c == 4);
            half();
            if (c <= 2) begin
                chk($sformatf("t5_ready_c%0d", c), 64'(nif.nice_req_ready), 64'd0);
                chk($sformatf("t5_type_c%0d", c), 64'(nif.nice_rsp_1cyc_type), 64'd0);
            end
            edge_();
        end
        fin = 1'b0;
        nif.nice_rsp_multicyc_ready = 1'b1;
        half();
        edge_();
        nif.nice_rsp_multicyc_ready = 1'b0;
        chk("t5_slot0_kept", 64'(param_flat[0 +: DW]), 64'h400);
        chk("t5_slot1_kept", 64'(param_flat[DW +: DW]), 64'h480);
        fin = 1'b1;
        half();
        edge_();
        fin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            half();
            chk($sformatf("t5_idle_fin_%0d", c), 64'(nif.nice_rsp_multicyc_valid), 64'd0);
            edge_();
        end

        // fin coincident with START is ignored; reset mid-RUN aborts silently
        for (int i = 0; i < 8; i++) wr(i, 32'h500 + 32'(i), 32'h580 + 32'(i));
        req_set(OPC, 3'b010, 7'd0, 0, 0);
        fin = 1'b1;
        half();
        chk("t6_start", 64'(start), 64'd1);
        edge_();
        req_clr();
        fin = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            half();
            chk($sformatf("t6_busy_c%0d", c), 64'(busy), 64'd1);
            chk($sformatf("t6_mvalid_c%0d", c), 64'(nif.nice_rsp_multicyc_valid), 64'd0);
            edge_();
        end
        #2;
        nice_rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_start", 64'(start), 64'd0);
        chk("t6_rst_mvalid", 64'(nif.nice_rsp_multicyc_valid), 64'd0);
        chk("t6_rst_mdat", 64'(nif.nice_rsp_multicyc_dat), 64'd0);
        chk("t6_rst_vld", 64'(param_vld), 64'd0);
        chk("t6_rst_flat", 64'(|param_flat), 64'd0);
        chk("t6_rst_ready", 64'(nif.nice_req_ready), 64'd1);
        @(negedge nice_clk);
        nice_rst_n = 1'b1;
        edge_();
        for (int c = 0; c < 4; c++) begin
            half();
            chk($sformatf("t6_post_mvalid_%0d", c), 64'(nif.nice_rsp_multicyc_valid), 64'd0);
            edge_();
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
